// File: rtl/html_doc_streamer_pkg.sv
// Shared character constants and FSM encodings for the HTML document streamer.
package html_doc_streamer_pkg;

    localparam int unsigned CHAR_BITES = 8;

    localparam logic [CHAR_BITES-1:0] CH_NUL = 8'h00;
    localparam logic [CHAR_BITES-1:0] CH_TAB = 8'h09;
    localparam logic [CHAR_BITES-1:0] CH_LF  = 8'h0A;
    localparam logic [CHAR_BITES-1:0] CH_CR  = 8'h0D;
    localparam logic [CHAR_BITES-1:0] CH_SP  = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StHold,
        StDrain,
        StDone
    } pres_state_e;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchAddr,
        FetchEval,
        FetchStop
    } fetch_state_e;

    function automatic logic is_space(input logic [CHAR_BITES-1:0] c);
        return (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    endfunction

endpackage

// File: rtl/html_doc_streamer_fetch.sv
// ROM fetch pipeline with whitespace collapse and a one-entry next buffer.
module doc_fetch_unit
    import html_doc_streamer_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 12,
    parameter int unsigned DOC_LENGTH = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  take,
    input  logic [CHAR_BITES-1:0] rom_data,
    output logic [ADDR_BITS-1:0]  rom_addr,
    output logic                  next_valid,
    output logic [CHAR_BITES-1:0] next_char,
    output logic                  next_is_end
);

    // One extra bit so the address can actually reach DOC_LENGTH.
    localparam int unsigned CntBits = ADDR_BITS + 1;
    localparam logic [CntBits-1:0] DocEnd = CntBits'(DOC_LENGTH);

    fetch_state_e          state_q, state_d;
    logic [CntBits-1:0]    addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [CHAR_BITES-1:0] char_q, char_d;
    logic                  end_q, end_d;
    logic                  prev_space_q, prev_space_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FetchIdle;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            char_q       <= '0;
            end_q        <= 1'b0;
            prev_space_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            char_q       <= char_d;
            end_q        <= end_d;
            prev_space_q <= prev_space_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        char_d       = char_q;
        end_d        = end_q;
        prev_space_d = prev_space_q;

        if (take) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            FetchIdle, FetchStop: state_d = state_q;
            FetchAddr:            state_d = FetchEval;
            FetchEval: begin
                // rom_addr is held steady while stalled, so rom_data stays valid.
                if (!valid_q || take) begin
                    if ((addr_q == DocEnd) || (rom_data == CH_NUL)) begin
                        valid_d = 1'b1;
                        end_d   = 1'b1;
                        state_d = FetchStop;
                    end else if (is_space(rom_data)) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FetchAddr;
                        if (!prev_space_q) begin
                            valid_d      = 1'b1;
                            end_d        = 1'b0;
                            char_d       = CH_SP;
                            prev_space_d = 1'b1;
                        end
                    end else begin
                        valid_d      = 1'b1;
                        end_d        = 1'b0;
                        char_d       = rom_data;
                        prev_space_d = 1'b0;
                        addr_d       = addr_q + 1'b1;
                        state_d      = FetchAddr;
                    end
                end
            end
            default: state_d = FetchIdle;
        endcase

        if (restart) begin
            state_d      = FetchAddr;
            addr_d       = '0;
            valid_d      = 1'b0;
            end_d        = 1'b0;
            prev_space_d = 1'b1;
        end
    end

    assign rom_addr    = addr_q[ADDR_BITS-1:0];
    assign next_valid  = valid_q;
    assign next_char   = char_q;
    assign next_is_end = end_q;

endmodule

// File: rtl/html_doc_streamer.sv
// Streams a ROM-resident HTML document onto the parser char input with backpressure.
module html_doc_streamer
    import html_doc_streamer_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned DOC_LENGTH  = 4096,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [CHAR_BITES-1:0] rom_data,
    output logic [CHAR_BITES-1:0] char,
    output logic                  state_enable,
    output logic                  done
);

    localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    pres_state_e           state_q, state_d;
    logic [CHAR_BITES-1:0] char_q, char_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic [HoldW-1:0]      cnt_q, cnt_d;

    logic                  take;
    logic                  restart;
    logic                  next_valid;
    logic [CHAR_BITES-1:0] next_char;
    logic                  next_is_end;

    doc_fetch_unit #(
        .ADDR_BITS  (ADDR_BITS),
        .DOC_LENGTH (DOC_LENGTH)
    ) u_fetch (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .take        (take),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .next_valid  (next_valid),
        .next_char   (next_char),
        .next_is_end (next_is_end)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            char_q   <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        enable_d = enable_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        restart  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    restart = 1'b1;
                    done_d  = 1'b0;
                    state_d = StPrime;
                end
            end
            StPrime: begin
                if (next_valid) begin
                    take = 1'b1;
                    if (next_is_end) begin
                        state_d = StDrain;
                    end else begin
                        char_d   = next_char;
                        enable_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = StHold;
                    end
                end
            end
            StHold: begin
                // pause only matters once the minimum hold has elapsed.
                if (cnt_q != HoldLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!pause && next_valid) begin
                    take = 1'b1;
                    if (next_is_end) begin
                        state_d = StDrain;
                    end else begin
                        char_d = next_char;
                        cnt_d  = '0;
                    end
                end
            end
            StDrain: begin
                if (!pause) begin
                    enable_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign char         = char_q;
    assign state_enable = enable_q;
    assign done         = done_q;

endmodule

// File: tb/tb_html_doc_streamer.sv
// Directed self-checking bench for html_doc_streamer.
module tb_html_doc_streamer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pause;
    logic       start_a, start_b;
    logic [5:0] rom_addr_a;
    logic [3:0] rom_addr_b;
    logic [7:0] rom_data_a, rom_data_b;
    logic [7:0] char_a, char_b;
    logic       en_a, en_b, done_a, done_b;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [16];
    logic [7:0] cap_q [$];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data_a <= mem_a[rom_addr_a];
    always @(posedge clock) rom_data_b <= mem_b[rom_addr_b];

    html_doc_streamer #(
        .ADDR_BITS   (6),
        .DOC_LENGTH  (64),
        .HOLD_CYCLES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start_a),
        .pause        (pause),
        .rom_addr     (rom_addr_a),
        .rom_data     (rom_data_a),
        .char         (char_a),
        .state_enable (en_a),
        .done         (done_a)
    );

    html_doc_streamer #(
        .ADDR_BITS   (4),
        .DOC_LENGTH  (4),
        .HOLD_CYCLES (2)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .start        (start_b),
        .pause        (pause),
        .rom_addr     (rom_addr_b),
        .rom_data     (rom_data_b),
        .char         (char_b),
        .state_enable (en_b),
        .done         (done_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_a(input string s);
        for (int i = 0; i < 64; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem_a[i] = s[i];
    endtask

    // Leaves the bench just after edge 0 of the new document.
    task automatic kick_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic capture_a(input int budget);
        logic       prev_en;
        logic [7:0] prev_ch;
        cap_q.delete();
        prev_en = en_a;
        prev_ch = char_a;
        for (int i = 0; i < budget && !done_a; i++) begin
            tick();
            if (en_a && (!prev_en || char_a != prev_ch)) cap_q.push_back(char_a);
            prev_en = en_a;
            prev_ch = char_a;
        end
    endtask

    task automatic finish_a(input string name);
        for (int i = 0; i < 100 && !done_a; i++) tick();
        total++;
        if (done_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_done got=%b exp=1", name, done_a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        total++; if (char_a !== 8'h00) begin bad++; $display("FAIL reset_char got=%h exp=00", char_a); end
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", en_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        total++; if (rom_addr_a !== 6'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rom_addr_a); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_a("ab");
        kick_a();
        tick(); tick();
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL basic_en_e2 got=%b exp=0", en_a); end
        tick();
        total++; if (char_a !== 8'h61) begin bad++; $display("FAIL basic_a_e3 got=%h exp=61", char_a); end
        total++; if (en_a !== 1'b1) begin bad++; $display("FAIL basic_en_e3 got=%b exp=1", en_a); end
        tick();
        total++; if (char_a !== 8'h61) begin bad++; $display("FAIL basic_a_e4 got=%h exp=61", char_a); end
        tick();
        total++; if (char_a !== 8'h62) begin bad++; $display("FAIL basic_b_e5 got=%h exp=62", char_a); end
        tick(); tick();
        total++; if ({en_a, done_a} !== 2'b10) begin bad++; $display("FAIL basic_e7 en_done=%b exp=10", {en_a, done_a}); end
        tick();
        total++; if ({en_a, done_a} !== 2'b01) begin bad++; $display("FAIL basic_e8 en_done=%b exp=01", {en_a, done_a}); end
        total++; if (char_a !== 8'h62) begin bad++; $display("FAIL basic_keep got=%h exp=62", char_a); end
    endtask

    task automatic test_whitespace();
        string exp;
        load_a("a \n\t b");
        kick_a();
        capture_a(100);
        exp = "a b";
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL ws_done got=%b exp=1", done_a); end
        total++;
        if (cap_q.size() != 3) begin
            bad++; $display("FAIL ws_len got=%0d exp=3", cap_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (cap_q[i] !== 8'(exp[i])) begin
                    bad++; $display("FAIL ws_char%0d got=%h exp=%h", i, cap_q[i], 8'(exp[i]));
                end
            end
        end
        load_a("   x");
        kick_a();
        capture_a(100);
        total++;
        if (cap_q.size() != 1 || cap_q[0] !== 8'h78) begin
            bad++; $display("FAIL lead_ws got_len=%0d exp_len=1 first exp=78", cap_q.size());
        end
    endtask

    task automatic test_blank();
        logic rose = 1'b0;
        load_a("  \t ");
        kick_a();
        for (int i = 0; i < 40 && !done_a; i++) begin
            tick();
            if (en_a) rose = 1'b1;
        end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL blank_done got=%b exp=1", done_a); end
        total++; if (rose !== 1'b0) begin bad++; $display("FAIL blank_en rose=%b exp=0", rose); end
    endtask

    task automatic test_pause_hold();
        logic held = 1'b1;
        load_a("<p>hi");
        kick_a();
        for (int i = 0; i < 40 && char_a != 8'h68; i++) tick();
        total++; if (char_a !== 8'h68) begin bad++; $display("FAIL pause_reach_h got=%h exp=68", char_a); end
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (char_a !== 8'h68) held = 1'b0;
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL pause_held got=%h exp=68", char_a); end
        pause = 1'b0;
        tick();
        total++; if (char_a !== 8'h69) begin bad++; $display("FAIL pause_release got=%h exp=69", char_a); end
        finish_a("pause");
    endtask

    task automatic test_drain_pause();
        logic stay = 1'b1;
        load_a("ab");
        kick_a();
        for (int i = 0; i < 7; i++) tick();
        total++; if ({en_a, done_a} !== 2'b10) begin bad++; $display("FAIL drain_enter en_done=%b exp=10", {en_a, done_a}); end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (en_a !== 1'b1 || done_a !== 1'b0) stay = 1'b0;
        end
        total++; if (stay !== 1'b1) begin bad++; $display("FAIL drain_hold en_done=%b exp=10", {en_a, done_a}); end
        pause = 1'b0;
        tick();
        total++; if ({en_a, done_a} !== 2'b01) begin bad++; $display("FAIL drain_exit en_done=%b exp=01", {en_a, done_a}); end
    endtask

    task automatic test_reset_mid();
        load_a("<p>hi");
        kick_a();
        for (int i = 0; i < 40 && char_a != 8'h70; i++) tick();
        pause = 1'b1;
        tick(); tick();
        total++; if (en_a !== 1'b1) begin bad++; $display("FAIL rmid_active got=%b exp=1", en_a); end
        #2 reset = 1'b1;
        #1;
        total++; if (char_a !== 8'h00) begin bad++; $display("FAIL rmid_char got=%h exp=00", char_a); end
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL rmid_en got=%b exp=0", en_a); end
        total++; if (rom_addr_a !== 6'd0) begin bad++; $display("FAIL rmid_addr got=%0d exp=0", rom_addr_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b exp=0", done_a); end
        #2 reset = 1'b0;
        pause = 1'b0;
        kick_a();
        tick(); tick(); tick();
        total++; if (char_a !== 8'h3c) begin bad++; $display("FAIL rmid_replay got=%h exp=3c", char_a); end
        total++; if (en_a !== 1'b1) begin bad++; $display("FAIL rmid_replay_en got=%b exp=1", en_a); end
        finish_a("rmid");
    endtask

    task automatic test_doc_length();
        logic       prev_en = 1'b0;
        logic [7:0] prev_ch;
        logic       pulsed = 1'b0;
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h61 + 8'(i);
        cap_q.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        prev_ch = char_b;
        for (int i = 0; i < 80 && !done_b; i++) begin
            tick();
            start_b = 1'b0;
            if (en_b && (!prev_en || char_b != prev_ch)) begin
                cap_q.push_back(char_b);
                if (char_b == 8'h62 && !pulsed) begin
                    start_b = 1'b1;
                    pulsed  = 1'b1;
                end
            end
            prev_en = en_b;
            prev_ch = char_b;
        end
        start_b = 1'b0;
        total++; if ({en_b, done_b} !== 2'b01) begin bad++; $display("FAIL len_done en_done=%b exp=01", {en_b, done_b}); end
        total++;
        if (cap_q.size() != 4) begin
            bad++; $display("FAIL len_count got=%0d exp=4", cap_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (cap_q[i] !== 8'h61 + 8'(i)) begin
                    bad++; $display("FAIL len_char%0d got=%h exp=%h", i, cap_q[i], 8'h61 + 8'(i));
                end
            end
        end
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        pause   = 1'b0;
        for (int i = 0; i < 64; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
        test_reset();
        test_basic();
        test_whitespace();
        test_blank();
        test_pause_hold();
        test_drain_pause();
        test_reset_mid();
        test_doc_length();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
